// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared select encoding for the 2-way stream mux/demux family.
//   sel_t   : 1-bit channel select
//   SEL_I0  : channel 0
//   SEL_I1  : channel 1
//   other_sel() : the opposite channel, used for round-robin hand-over
// -----------------------------------------------------------------------------
package mux_pkg;

   typedef logic sel_t;

   localparam sel_t SEL_I0 = 1'b0;
   localparam sel_t SEL_I1 = 1'b1;

   function automatic sel_t other_sel(input sel_t s);
      return ~s;
   endfunction

endpackage : mux_pkg

// File: rtl/rr_arb_2.sv
// -----------------------------------------------------------------------------
// rr_arb_2
// Two-requester arbiter. A lone requester always wins; on contention the
// winner is the channel held in the priority register, which passes to the
// other channel each time a granted beat is actually taken.
//
// Build option: MUX_2TO1_STREAM_FIXED_PRIO_EN
//   defined   -> fixed priority, channel 0 wins contention, no prio register
//   undefined -> round-robin (default)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (prio back to channel 0)
//   req[1:0]   in   request per channel (the *_valid inputs)
//   advance    in   granted beat accepted this cycle; hands priority over
//   grant      out  winning channel (sel_t), meaningful when grant_vld
//   grant_vld  out  at least one request present
// -----------------------------------------------------------------------------
module rr_arb_2
   import mux_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output sel_t       grant,
   output logic       grant_vld
);

`ifdef MUX_2TO1_STREAM_FIXED_PRIO_EN

   // No state in this build; keep the clocking ports referenced so the
   // port list stays identical to the round-robin build.
   logic unused_inputs;
   assign unused_inputs = &{1'b0, clk, rst, advance};

   always_comb begin
      grant_vld = |req;
      grant     = req[0] ? SEL_I0 : SEL_I1;
   end

`else

   sel_t prio_q;
   sel_t prio_d;

   always_comb begin
      grant_vld = |req;
      case (req)
         2'b01:   grant = SEL_I0;
         2'b10:   grant = SEL_I1;
         default: grant = prio_q;   // contention (or no request: don't care)
      endcase

      // Priority moves only when a beat is really taken, so a stalled
      // output never reshuffles the arbitration order.
      prio_d = prio_q;
      if (advance) begin
         prio_d = other_sel(grant);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= SEL_I0;
      end else begin
         prio_q <= prio_d;
      end
   end

`endif

endmodule : rr_arb_2

// File: rtl/mux_2to1_stream.sv
// -----------------------------------------------------------------------------
// mux_2to1_stream
// Registered 2-to-1 stream merger with valid/ready handshakes. Beats from two
// source channels are arbitrated (round-robin by default) and forwarded one
// at a time through a single output register, tagged with their source.
//
// Build option: MUX_2TO1_STREAM_FIXED_PRIO_EN (see rr_arb_2); when defined,
// channel 0 always wins contention. Ports and latency are unchanged.
//
// Parameters:
//   width       data width of inputs and output (default 4)
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   i0/i1       in   channel data
//   i0_valid    in   channel 0 beat present
//   i0_ready    out  channel 0 beat accepted this cycle
//   i1_valid    in   channel 1 beat present
//   i1_ready    out  channel 1 beat accepted this cycle
//   o           out  registered output data
//   o_valid     out  output register holds a beat
//   o_ready     in   downstream accepts the beat
//   o_sel       out  source of the current output beat (0 = i0, 1 = i1)
//
// Ready is combinational from o_ready/o_valid/arbitration state and the
// valid inputs, so sources must not make valid depend on ready.
// -----------------------------------------------------------------------------
module mux_2to1_stream
   import mux_pkg::*;
#(
   parameter int width = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [width-1:0] i0,
   input  logic             i0_valid,
   output logic             i0_ready,
   input  logic [width-1:0] i1,
   input  logic             i1_valid,
   output logic             i1_ready,
   output logic [width-1:0] o,
   output logic             o_valid,
   input  logic             o_ready,
   output logic             o_sel
);

   logic [width-1:0] o_q, o_d;
   logic             o_valid_q, o_valid_d;
   sel_t             o_sel_q, o_sel_d;

   logic load;
   logic accept;
   sel_t grant;
   logic grant_vld;

   rr_arb_2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       ({i1_valid, i0_valid}),
      .advance   (accept),
      .grant     (grant),
      .grant_vld (grant_vld)
   );

   always_comb begin
      // Register is free when empty or being drained this very cycle;
      // this is what gives one beat per cycle under continuous flow.
      load   = !o_valid_q || o_ready;
      accept = load && grant_vld && !rst;

      i0_ready = accept && (grant == SEL_I0);
      i1_ready = accept && (grant == SEL_I1);

      o_d       = o_q;
      o_sel_d   = o_sel_q;
      o_valid_d = o_valid_q;
      if (load) begin
         if (grant_vld) begin
            o_d       = (grant == SEL_I1) ? i1 : i0;
            o_sel_d   = grant;
            o_valid_d = 1'b1;
         end else begin
            // Drained with nothing to refill: data/tag keep their last values.
            o_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_q       <= '0;
         o_valid_q <= 1'b0;
         o_sel_q   <= SEL_I0;
      end else begin
         o_q       <= o_d;
         o_valid_q <= o_valid_d;
         o_sel_q   <= o_sel_d;
      end
   end

   assign o       = o_q;
   assign o_valid = o_valid_q;
   assign o_sel   = o_sel_q;

endmodule : mux_2to1_stream

// File: tb/tb_mux_2to1_stream.sv
// -----------------------------------------------------------------------------
// tb_mux_2to1_stream
// Directed phases (reset, single channel, contention, backpressure, reset
// mid-stall) followed by randomized traffic. A behavioural model tracks
// whether the output holds a beat and which channel wins the next tie; every
// beat it expects to be accepted is pushed into a scoreboard queue. A separate
// monitor on the falling edge checks valid/ready and pops/compares output
// beats as they are handed downstream.
// -----------------------------------------------------------------------------
module tb_mux_2to1_stream;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] i0, i1, o;
   logic         i0_valid, i1_valid, i0_ready, i1_ready;
   logic         o_valid, o_ready, o_sel;

   always #5 clk = ~clk;

   mux_2to1_stream #(.width(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .i0       (i0),
      .i0_valid (i0_valid),
      .i0_ready (i0_ready),
      .i1       (i1),
      .i1_valid (i1_valid),
      .i1_ready (i1_ready),
      .o        (o),
      .o_valid  (o_valid),
      .o_ready  (o_ready),
      .o_sel    (o_sel)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int beats    = 0;

   // Scoreboard entries: {data, source channel}
   logic [W:0] sb_q[$];

   // Reference model state
   bit m_full   = 1'b0;   // output register holds a beat
   bit m_next   = 1'b0;   // channel that wins the next tie
   bit last_rst = 1'b0;

   // Expectations for the current cycle, read by the monitor
   bit exp_valid     = 1'b0;
   bit exp_r0        = 1'b0;
   bit exp_r1        = 1'b0;
   bit exp_after_rst = 1'b0;
   bit flush         = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Drive one cycle of stimulus and advance the reference model.
   task automatic cycle(input bit r, input bit v0, input logic [W-1:0] d0,
                        input bit v1, input logic [W-1:0] d1, input bit ordy);
      bit room, any, win;
      rst      = r;
      i0_valid = v0;
      i0       = d0;
      i1_valid = v1;
      i1       = d1;
      o_ready  = ordy;

      exp_valid     = m_full;
      exp_after_rst = last_rst;
      last_rst      = r;
      flush         = r;

      if (r) begin
         exp_r0 = 1'b0;
         exp_r1 = 1'b0;
         m_full = 1'b0;
         m_next = 1'b0;
      end else begin
         room = !m_full || ordy;
         any  = v0 || v1;
`ifdef MUX_2TO1_STREAM_FIXED_PRIO_EN
         win = !v0;
`else
         win = (v0 && v1) ? m_next : v1;
`endif
         exp_r0 = room && any && !win;
         exp_r1 = room && any && win;
         if (room) begin
            if (any) begin
               sb_q.push_back({(win ? d1 : d0), win});
               m_full = 1'b1;
               m_next = !win;
            end else begin
               m_full = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: samples mid-cycle, when inputs and outputs are settled.
   initial begin
      forever begin
         @(negedge clk);
         check("o_valid", o_valid, exp_valid);
         check("i0_ready", i0_ready, exp_r0);
         check("i1_ready", i1_ready, exp_r1);
         if (exp_after_rst) begin
            check("rst_o", o, 0);
            check("rst_o_sel", o_sel, 0);
         end
         if (o_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               $display("FAIL beat: o_valid high with no expected beat, got o=%0h sel=%0d", o, o_sel);
            end else begin
               check("o_data", o, sb_q[0][W:1]);
               check("o_sel", o_sel, sb_q[0][0]);
               if (o_ready) begin
                  $display("beat %0d: o=%h sel=%0d", beats, o, o_sel);
                  beats++;
                  void'(sb_q.pop_front());
               end
            end
         end
         if (flush) sb_q.delete();
      end
   end

   initial begin
      bit r, v0, v1, ordy;
      // Reset with both channels requesting
      for (int k = 0; k < 3; k++) cycle(1, 1, 4'h5, 1, 4'h6, 1);
      // Single channel 0, then single channel 1
      cycle(0, 1, 4'hA, 0, 4'h0, 1);
      cycle(0, 0, 4'h0, 0, 4'h0, 1);
      cycle(0, 0, 4'h0, 1, 4'hD, 1);
      cycle(0, 0, 4'h0, 0, 4'h0, 1);
      // Continuous contention
      for (int k = 0; k < 6; k++) cycle(0, 1, 4'hB, 1, 4'hC, 1);
      cycle(0, 0, 4'h0, 0, 4'h0, 1);
      // Backpressure: load A, stall 4 cycles with new inputs waiting, release
      cycle(0, 1, 4'hA, 0, 4'h0, 1);
      for (int k = 0; k < 4; k++) cycle(0, 1, 4'h3, 1, 4'h7, 0);
      cycle(0, 1, 4'h3, 1, 4'h7, 1);
      cycle(0, 0, 4'h0, 0, 4'h0, 1);
      cycle(0, 0, 4'h0, 0, 4'h0, 1);
      // Reset mid-stall, then contention must restart on channel 0
      cycle(0, 0, 4'h0, 1, 4'h9, 1);
      cycle(0, 1, 4'h1, 1, 4'h2, 0);
      cycle(1, 1, 4'h1, 1, 4'h2, 0);
      for (int k = 0; k < 4; k++) cycle(0, 1, 4'hB, 1, 4'hC, 1);
      // Randomized traffic with occasional resets
      for (int k = 0; k < 600; k++) begin
         r    = ($urandom_range(0, 59) == 0);
         v0   = ($urandom_range(0, 2) != 0);
         v1   = ($urandom_range(0, 2) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         cycle(r, v0, W'($urandom), v1, W'($urandom), ordy);
      end
      for (int k = 0; k < 3; k++) cycle(0, 0, 4'h0, 0, 4'h0, 1);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_mux_2to1_stream

// File: doc/mux_2to1_stream.md
# mux_2to1_stream

Registered 2-to-1 stream merger with valid/ready handshakes. It collects beats from two independent `width`-bit source channels and forwards them one at a time onto a single output channel. Each output beat is tagged with the channel it came from, and contention between the sources is resolved by round-robin arbitration. It is the merging counterpart of the 1-to-2 demux: a demux's `o0`/`o1` streams can be recombined here, with `o_sel` restoring the original select.

## Interface
Parameters:
- `width`, default 4: data width of each input and of the output.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `i0` input `width`: channel 0 data.
- `i0_valid` input 1: channel 0 beat present.
- `i0_ready` output 1: channel 0 beat accepted this cycle.
- `i1` input `width`: channel 1 data.
- `i1_valid` input 1: channel 1 beat present.
- `i1_ready` output 1: channel 1 beat accepted this cycle.
- `o` output `width`: registered output data.
- `o_valid` output 1: output register holds a beat.
- `o_ready` input 1: downstream accepts the beat.
- `o_sel` output 1: source of the current output beat (0 = `i0`, 1 = `i1`).

## Operation
- Transfer rule: a transfer happens on any channel when valid and ready are both high at a rising edge.
- Load enable: `load = !o_valid || o_ready`. The output register can take a new beat when it is empty or is being drained in the same cycle.
- Grant rule:
  - Only `iK_valid` high: grant goes to K.
  - Both valid: grant goes to channel `prio`.
  - Neither valid: no grant.
- `iK_ready = load && grant == K && !rst`. Ready is combinational from `o_ready`, `o_valid`, `prio` and the `*_valid` inputs. Sources must not make valid depend on ready.
- On a grant with `load` high, at the next edge:
  - `o <= iK`
  - `o_sel <= K`
  - `o_valid <= 1`
  - `prio <= ~K`
- On `load` high with no grant: `o_valid <= 0`. `o` and `o_sel` hold their last values.
- On `load` low: all output state holds, and `o`/`o_sel` stay stable while `o_valid && !o_ready`.
- Simultaneous drain and refill in the same cycle gives full throughput: one beat per cycle sustained.
- `prio` changes only on an accepted input beat. It never changes while stalled.

## Timing
- Latency: 1 cycle from input transfer to `o_valid`.
- Throughput: 1 beat per cycle. Under continuous contention the bench sees strict alternation 0,1,0,1…
- Reset values: `o = 0`, `o_valid = 0`, `o_sel = 0`, `prio = 0`.
- While `rst` is high, `i0_ready = i1_ready = 0`.
- Reset mid-operation: a beat held in the output register is discarded at the reset edge. `o_valid` is 0 in the cycle after the reset edge regardless of `o_ready`.
- Stall: a beat held with `o_ready` low holds indefinitely. No input is accepted during the stall.

## Configuration
- Macro `MUX_2TO1_STREAM_FIXED_PRIO_EN`.
- Defined: fixed priority, channel 0 always wins contention. The `prio` register is removed and grant is `i0_valid ? 0 : 1`.
- Undefined (default): round-robin as described under Operation.
- Port list and latency are identical in both builds.

## Structure
- Shared package `mux_pkg`:
  - `SEL_I0 = 1'b0` and `SEL_I1 = 1'b1`.
  - `sel_t` typedef, 1 bit.
  - Reused by the demux family for select encoding.
- One sub-module, `rr_arb_2`:
  - Inputs: `req[1:0]`, `advance`.
  - Output: `grant` (`sel_t`) plus `grant_vld`.
  - Owns the `prio` register and the macro switch.
- Top level: holds the output register and the handshake logic.

## Test plan
- Reset: hold `rst` high 3 cycles with both valids high. Required: `o_valid = 0`, `o = 0`, `o_sel = 0`, both readies 0.
- Single channel: `i0 = 4'hA`, `i0_valid = 1`, `o_ready = 1`, channel 1 idle. Required: next cycle `o = 4'hA`, `o_sel = 0`, `o_valid = 1`. Repeat on channel 1 with `4'hD`; required `o_sel = 1`.
- Contention, round-robin: both valid continuously (`i0 = 4'hB`, `i1 = 4'hC`), `o_ready = 1`. Required output sequence B,C,B,C, `o_sel` 0,1,0,1.
- Contention with `MUX_2TO1_STREAM_FIXED_PRIO_EN` defined: same stimulus. Required: `o = 4'hB` every cycle, `i1_ready` never high.
- Backpressure: beat `4'hA` loaded, then `o_ready = 0` for 4 cycles with new inputs valid. Required: `o = 4'hA` stable, `o_valid = 1`, both readies 0. On `o_ready = 1`, the next granted beat appears one cycle later with no loss or duplication.
- Reset mid-stall: assert `rst` for 1 cycle while `o_valid = 1`, `o_ready = 0`. Required: `o_valid = 0` and `prio = 0` after the edge. The next contention grants channel 0 first.
